// File: rtl/tl_ul_arbiter_2to1.sv
// tl_ul_arbiter_2to1
//   Shares one TileLink-UL master port between two client ports.
//   A channel: round-robin between clients, grant held for multi-beat Put
//   messages, master source = {client index, client source}.
//   D channel: responses steered back by the top source bit.
//   Outstanding messages are counted per client and capped at MAX_OUTST.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   c0_a_* / c1_a_*         client A channels (ready is an output)
//   c0_d_* / c1_d_*         client D channels (ready is an input)
//   m_a_* / m_d_*           shared master A / D channels
//   proto_err               sticky: D response for a client with nothing outstanding
//   busy                    messages outstanding or A burst in progress
module tl_ul_arbiter_2to1 #(
    parameter int SRC_W     = 3,
    parameter int ADDR_W    = 31,
    parameter int MAX_OUTST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    // client 0 A
    input  logic              c0_a_valid,
    output logic              c0_a_ready,
    input  logic [2:0]        c0_a_opcode,
    input  logic [2:0]        c0_a_param,
    input  logic [2:0]        c0_a_size,
    input  logic [SRC_W-1:0]  c0_a_source,
    input  logic [ADDR_W-1:0] c0_a_address,
    input  logic [3:0]        c0_a_mask,
    input  logic [31:0]       c0_a_data,
    // client 0 D
    output logic              c0_d_valid,
    input  logic              c0_d_ready,
    output logic [2:0]        c0_d_opcode,
    output logic [2:0]        c0_d_size,
    output logic [1:0]        c0_d_param,
    output logic [SRC_W-1:0]  c0_d_source,
    output logic              c0_d_denied,
    output logic              c0_d_corrupt,
    output logic [31:0]       c0_d_data,
    // client 1 A
    input  logic              c1_a_valid,
    output logic              c1_a_ready,
    input  logic [2:0]        c1_a_opcode,
    input  logic [2:0]        c1_a_param,
    input  logic [2:0]        c1_a_size,
    input  logic [SRC_W-1:0]  c1_a_source,
    input  logic [ADDR_W-1:0] c1_a_address,
    input  logic [3:0]        c1_a_mask,
    input  logic [31:0]       c1_a_data,
    // client 1 D
    output logic              c1_d_valid,
    input  logic              c1_d_ready,
    output logic [2:0]        c1_d_opcode,
    output logic [2:0]        c1_d_size,
    output logic [1:0]        c1_d_param,
    output logic [SRC_W-1:0]  c1_d_source,
    output logic              c1_d_denied,
    output logic              c1_d_corrupt,
    output logic [31:0]       c1_d_data,
    // master A
    output logic              m_a_valid,
    input  logic              m_a_ready,
    output logic [2:0]        m_a_opcode,
    output logic [2:0]        m_a_param,
    output logic [2:0]        m_a_size,
    output logic [SRC_W:0]    m_a_source,
    output logic [ADDR_W-1:0] m_a_address,
    output logic [3:0]        m_a_mask,
    output logic [31:0]       m_a_data,
    // master D
    input  logic              m_d_valid,
    output logic              m_d_ready,
    input  logic [2:0]        m_d_opcode,
    input  logic [2:0]        m_d_size,
    input  logic [1:0]        m_d_param,
    input  logic [SRC_W:0]    m_d_source,
    input  logic              m_d_denied,
    input  logic              m_d_corrupt,
    input  logic [31:0]       m_d_data,
    // status
    output logic              proto_err,
    output logic              busy
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTST);

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e     state_q, state_d;
    logic       lock_q, lock_d;        // client owning the current burst
    logic       rr_q, rr_d;            // preferred client when both are eligible
    logic [5:0] a_beat_q, a_beat_d;    // A beats still to come in the burst
    logic [5:0] d_beat_q, d_beat_d;    // D beats still to come; 0 = next beat is a first beat
    logic [2:0] outst_q [2];
    logic [2:0] outst_d [2];
    logic       proto_err_q, proto_err_d;
    logic [1:0] cnt_err;

    logic       elig0, elig1, gnt, gnt_act, a_fire, a_last;
    logic       d_tag, d_fire, d_last;
    logic [5:0] a_beats, d_beats;

    // 2^(size-2) beats for sizes above one 32-bit word, else a single beat
    function automatic logic [5:0] beats_of(input logic [2:0] size);
        logic [5:0] r;
        r = 6'd1;
        if (size > 3'd2) begin
            r = 6'd1 << (size - 3'd2);
        end
        return r;
    endfunction

    // ---------------- A channel arbitration ----------------
    always_comb begin
        elig0 = c0_a_valid && (outst_q[0] < MAX_CNT);
        elig1 = c1_a_valid && (outst_q[1] < MAX_CNT);
        if (state_q == ST_BURST) begin
            // grant is pinned to the burst owner, limits are not re-checked
            gnt     = lock_q;
            gnt_act = 1'b1;
        end else begin
            gnt     = (elig0 && elig1) ? rr_q : elig1;
            gnt_act = elig0 || elig1;
        end
    end

    assign m_a_valid   = gnt_act && (gnt ? c1_a_valid : c0_a_valid);
    assign c0_a_ready  = gnt_act && !gnt && m_a_ready;
    assign c1_a_ready  = gnt_act &&  gnt && m_a_ready;
    assign m_a_opcode  = gnt ? c1_a_opcode  : c0_a_opcode;
    assign m_a_param   = gnt ? c1_a_param   : c0_a_param;
    assign m_a_size    = gnt ? c1_a_size    : c0_a_size;
    assign m_a_source  = {gnt, (gnt ? c1_a_source : c0_a_source)};
    assign m_a_address = gnt ? c1_a_address : c0_a_address;
    assign m_a_mask    = gnt ? c1_a_mask    : c0_a_mask;
    assign m_a_data    = gnt ? c1_a_data    : c0_a_data;

    assign a_fire  = m_a_valid && m_a_ready;
    // only PutFullData(0) / PutPartialData(1) carry multiple A beats
    assign a_beats = (m_a_opcode == 3'd0 || m_a_opcode == 3'd1) ? beats_of(m_a_size) : 6'd1;
    assign a_last  = a_fire && ((state_q == ST_BURST) ? (a_beat_q == 6'd1) : (a_beats == 6'd1));

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        a_beat_d = a_beat_q;
        rr_d     = rr_q;
        if (a_fire) begin
            if (state_q == ST_IDLE) begin
                if (a_beats != 6'd1) begin
                    state_d  = ST_BURST;
                    lock_d   = gnt;
                    a_beat_d = a_beats - 6'd1;
                end
            end else begin
                a_beat_d = a_beat_q - 6'd1;
                if (a_beat_q == 6'd1) begin
                    state_d = ST_IDLE;
                end
            end
        end
        if (a_last) begin
            rr_d = ~gnt;
        end
    end

    // ---------------- D channel routing ----------------
    assign d_tag        = m_d_source[SRC_W];
    assign c0_d_valid   = m_d_valid && !d_tag;
    assign c1_d_valid   = m_d_valid &&  d_tag;
    assign m_d_ready    = d_tag ? c1_d_ready : c0_d_ready;
    assign c0_d_opcode  = m_d_opcode;
    assign c1_d_opcode  = m_d_opcode;
    assign c0_d_size    = m_d_size;
    assign c1_d_size    = m_d_size;
    assign c0_d_param   = m_d_param;
    assign c1_d_param   = m_d_param;
    assign c0_d_source  = m_d_source[SRC_W-1:0];
    assign c1_d_source  = m_d_source[SRC_W-1:0];
    assign c0_d_denied  = m_d_denied;
    assign c1_d_denied  = m_d_denied;
    assign c0_d_corrupt = m_d_corrupt;
    assign c1_d_corrupt = m_d_corrupt;
    assign c0_d_data    = m_d_data;
    assign c1_d_data    = m_d_data;

    assign d_fire  = m_d_valid && m_d_ready;
    // only AccessAckData(1) carries multiple D beats
    assign d_beats = (m_d_opcode == 3'd1) ? beats_of(m_d_size) : 6'd1;
    assign d_last  = d_fire && ((d_beat_q == 6'd0) ? (d_beats == 6'd1) : (d_beat_q == 6'd1));

    always_comb begin
        d_beat_d = d_beat_q;
        if (d_fire) begin
            d_beat_d = (d_beat_q == 6'd0) ? (d_beats - 6'd1) : (d_beat_q - 6'd1);
        end
    end

    // ---------------- per-client outstanding counters ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_outst
            logic       inc, dec;
            logic [2:0] cnt_d;
            logic       err;
            always_comb begin
                inc   = a_last && (gnt == 1'(gi));
                dec   = d_last && (d_tag == 1'(gi));
                cnt_d = outst_q[gi];
                err   = dec && (outst_q[gi] == 3'd0);
                // a message leaving and one completing in the same cycle cancel out
                if (inc && !dec) begin
                    cnt_d = outst_q[gi] + 3'd1;
                end else if (dec && !inc && (outst_q[gi] != 3'd0)) begin
                    cnt_d = outst_q[gi] - 3'd1;
                end
            end
            assign outst_d[gi] = cnt_d;
            assign cnt_err[gi] = err;
        end
    endgenerate

    assign proto_err_d = proto_err_q || (|cnt_err);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lock_q      <= 1'b0;
            rr_q        <= 1'b0;
            a_beat_q    <= 6'd0;
            d_beat_q    <= 6'd0;
            outst_q[0]  <= 3'd0;
            outst_q[1]  <= 3'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            a_beat_q    <= a_beat_d;
            d_beat_q    <= d_beat_d;
            outst_q[0]  <= outst_d[0];
            outst_q[1]  <= outst_d[1];
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
    assign busy      = (outst_q[0] != 3'd0) || (outst_q[1] != 3'd0) || (state_q == ST_BURST);

endmodule
